// File: rtl/jpeg_dequant_rle_if.sv
// ----------------------------------------------------------------------------
// jpeg_dequant_rle_if
// Symbol, quant-table and coefficient-write bus for the dequant/RLE stage.
//   master : upstream side (Huffman decoder, table loader, IDCT release)
//   slave  : the jpeg_dequant_rle stage itself
// Signals:
//   QtWe/QtTable/QtAddr/QtData          quant table write port
//   SymValid/SymReady/SymRun/SymValue/
//   SymEob/SymTable                     (run, value) symbol handshake
//   NextBlockEnable                     downstream releases a parked block
//   DataOutEnable/DataOutAddress/DataOut coefficient write to zigzag regfile
//   BlockDone/RunError                  block complete pulse, sticky overrun
// ----------------------------------------------------------------------------
interface jpeg_dequant_rle_if #(
   parameter int unsigned NUM_TABLES = 2
);
   localparam int unsigned TW = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;

   logic          QtWe;
   logic [TW-1:0] QtTable;
   logic [5:0]    QtAddr;
   logic [7:0]    QtData;

   logic          SymValid;
   logic          SymReady;
   logic [3:0]    SymRun;
   logic [11:0]   SymValue;
   logic          SymEob;
   logic [TW-1:0] SymTable;

   logic          NextBlockEnable;

   logic          DataOutEnable;
   logic [5:0]    DataOutAddress;
   logic [15:0]   DataOut;
   logic          BlockDone;
   logic          RunError;

   modport master (
      output QtWe, QtTable, QtAddr, QtData,
      output SymValid, SymRun, SymValue, SymEob, SymTable,
      output NextBlockEnable,
      input  SymReady,
      input  DataOutEnable, DataOutAddress, DataOut, BlockDone, RunError
   );

   modport slave (
      input  QtWe, QtTable, QtAddr, QtData,
      input  SymValid, SymRun, SymValue, SymEob, SymTable,
      input  NextBlockEnable,
      output SymReady,
      output DataOutEnable, DataOutAddress, DataOut, BlockDone, RunError
   );
endinterface

// File: rtl/jpeg_dequant_rle.sv
// ----------------------------------------------------------------------------
// jpeg_dequant_rle
// Expands Huffman-decoded (run, value) symbols of one 8x8 block into zigzag
// coefficient writes, multiplying each value by its quantisation entry.
// Parks after every block until the downstream IDCT releases it.
// Ports:
//   clk   clock
//   rst   asynchronous reset, active low (quant tables keep contents)
//   bus   jpeg_dequant_rle_if.slave (symbol in, table load, coefficient out)
// Configuration:
//   DEQUANT_SATURATE_EN  defined  : product clamped to [-32768, 32767]
//                        undefined: product wraps to its low 16 bits
// ----------------------------------------------------------------------------
module jpeg_dequant_rle #(
   parameter int unsigned NUM_TABLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   jpeg_dequant_rle_if.slave    bus
);

   localparam int unsigned TW = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
   localparam int unsigned NT = 1 << TW;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Quantisation tables; storage rounded up to a power of two so any select is in range
   logic [7:0] qt_q [NT][64];

   logic [1:0]    state_q, state_d;
   logic [5:0]    idx_q, idx_d;
   logic [TW-1:0] tbl_q, tbl_d;
   logic          rdy_q, rdy_d;
   logic          we_q, we_d;
   logic [5:0]    addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic                accept;
   logic [6:0]          tgt;
   logic [TW-1:0]       q_sel;
   logic [5:0]          q_addr;
   logic [7:0]          q_val;
   logic signed [19:0]  val_x;
   logic signed [19:0]  q_x;
   logic signed [19:0]  prod;
   logic [15:0]         coef;

   // Table write port, accepted in any state; reads see the pre-write value
   always_ff @(posedge clk) begin
      if (bus.QtWe) begin
         qt_q[bus.QtTable][bus.QtAddr] <= bus.QtData;
      end
   end

   assign accept = bus.SymValid & rdy_q;

   // Target index: zeros skipped plus the value slot itself (7 bits to catch overrun)
   assign tgt = 7'(idx_q) + 7'(bus.SymRun) + 7'd1;

   // DC term uses entry 0 of the table being latched; AC terms use the latched table
   assign q_sel  = (state_q == ST_IDLE) ? bus.SymTable : tbl_q;
   assign q_addr = (state_q == ST_IDLE) ? 6'd0 : tgt[5:0];
   assign q_val  = qt_q[q_sel][q_addr];

   // 12b signed x 8b unsigned always fits in 20b signed
   assign val_x = {{8{bus.SymValue[11]}}, bus.SymValue};
   assign q_x   = {12'd0, q_val};
   assign prod  = val_x * q_x;

`ifdef DEQUANT_SATURATE_EN
   localparam logic signed [19:0] COEF_MAX = 20'sd32767;
   localparam logic signed [19:0] COEF_MIN = -20'sd32768;

   // Clamp to the 16-bit coefficient range
   always_comb begin
      coef = prod[15:0];
      if (prod > COEF_MAX) begin
         coef = 16'h7FFF;
      end else if (prod < COEF_MIN) begin
         coef = 16'h8000;
      end
   end
`else
   // Plain two's complement wrap
   assign coef = prod[15:0];
`endif

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 6'd0;
         tbl_q   <= '0;
         rdy_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 6'd0;
         data_q  <= 16'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tbl_q   <= tbl_d;
         rdy_q   <= rdy_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tbl_d   = tbl_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            // DC always lands at address 0 so the downstream clears the rest
            if (accept) begin
               tbl_d  = bus.SymTable;
               we_d   = 1'b1;
               addr_d = 6'd0;
               idx_d  = 6'd0;
               if (bus.SymEob) begin
                  data_d  = 16'd0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  data_d  = coef;
                  state_d = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (accept) begin
               if (bus.SymEob) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else if (tgt > 7'd63) begin
                  // Overrun: drop the symbol and close the block
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  // ZRL (run 15, value 0) advances by 16 through the same target path
                  idx_d = tgt[5:0];
                  if (bus.SymValue != 12'd0) begin
                     we_d   = 1'b1;
                     addr_d = tgt[5:0];
                     data_d = coef;
                  end
                  if (tgt == 7'd63) begin
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end
               end
            end
         end

         ST_DONE: begin
            if (bus.NextBlockEnable) begin
               state_d = ST_IDLE;
               idx_d   = 6'd0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            idx_d   = 6'd0;
         end
      endcase

      rdy_d = (state_d != ST_DONE);
   end

   assign bus.SymReady       = rdy_q;
   assign bus.DataOutEnable  = we_q;
   assign bus.DataOutAddress = addr_q;
   assign bus.DataOut        = data_q;
   assign bus.BlockDone      = done_q;
   assign bus.RunError       = err_q;

endmodule

// File: tb/tb_jpeg_dequant_rle.sv
// ----------------------------------------------------------------------------
// tb_jpeg_dequant_rle
// Directed scenarios plus randomized blocks, checked against a block-level
// reference model of run expansion and dequantisation.
// ----------------------------------------------------------------------------
module tb_jpeg_dequant_rle;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   jpeg_dequant_rle_if #(.NUM_TABLES(2)) bus ();

   jpeg_dequant_rle #(.NUM_TABLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int run;
      int val;
      bit eob;
   } sym_t;

   sym_t syms[$];
   int   qt_m [2][64];
   int   exp_addr[$];
   int   exp_data[$];
   bit   exp_err;
   bit   exp_end_we;
   bit   err_model;

   int   got_addr[$];
   int   got_data[$];
   int   done_cnt;
   bit   done_we;

   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Coefficient capture from the write port
   always @(negedge clk) begin
      if (bus.DataOutEnable) begin
         got_addr.push_back(int'(bus.DataOutAddress));
         got_data.push_back(int'(bus.DataOut));
      end
      if (bus.BlockDone) begin
         done_cnt++;
         done_we = bus.DataOutEnable;
      end
   end

   function automatic int narrow(input int p);
      int r;
      r = p;
`ifdef DEQUANT_SATURATE_EN
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
`endif
      return r & 32'h0000FFFF;
   endfunction

   function automatic int rnd_val(input bit zero_ok);
      int v;
      case ($urandom_range(0, 5))
         0:       v = 2047;
         1:       v = -2048;
         default: v = int'($urandom_range(0, 4095)) - 2048;
      endcase
      if (!zero_ok && v == 0) v = 1;
      return v;
   endfunction

   task automatic add(input int run, input int val, input bit eob);
      sym_t s;
      s.run = run;
      s.val = val;
      s.eob = eob;
      syms.push_back(s);
   endtask

   // Block-level reference: position walk over the symbol list
   task automatic ref_block(input int t);
      int pos;
      int tg;
      exp_addr.delete();
      exp_data.delete();
      exp_err    = 1'b0;
      exp_end_we = 1'b0;
      if (syms[0].eob) begin
         exp_addr.push_back(0);
         exp_data.push_back(0);
         exp_end_we = 1'b1;
         return;
      end
      exp_addr.push_back(0);
      exp_data.push_back(narrow(syms[0].val * qt_m[t][0]));
      pos = 0;
      for (int i = 1; i < syms.size(); i++) begin
         if (syms[i].eob) break;
         tg = pos + syms[i].run + 1;
         if (tg > 63) begin
            exp_err = 1'b1;
            break;
         end
         if (syms[i].val != 0) begin
            exp_addr.push_back(tg);
            exp_data.push_back(narrow(syms[i].val * qt_m[t][tg]));
         end
         pos = tg;
         if (pos == 63) begin
            exp_end_we = (syms[i].val != 0);
            break;
         end
      end
   endtask

   // Legal random block: never overruns index 63
   task automatic gen_block();
      int pos;
      int mx;
      int run;
      syms.delete();
      if ($urandom_range(0, 15) == 0) begin
         add(int'($urandom_range(0, 15)), rnd_val(1'b1), 1'b1);
         return;
      end
      add(int'($urandom_range(0, 15)), rnd_val(1'b1), 1'b0);
      pos = 0;
      forever begin
         case ($urandom_range(0, 11))
            0: begin
               add(int'($urandom_range(0, 15)), rnd_val(1'b1), 1'b1);
               return;
            end
            1: begin
               if (pos <= 47) begin
                  add(15, 0, 1'b0);
                  pos += 16;
                  if (pos == 63) return;
                  continue;
               end
            end
            default: ;
         endcase
         mx = 62 - pos;
         if (mx > 15) mx = 15;
         run = int'($urandom_range(0, mx));
         add(run, rnd_val(1'b0), 1'b0);
         pos += run + 1;
         if (pos == 63) return;
      end
   endtask

   task automatic qt_write(input int t, input int a, input int d);
      bus.QtWe    = 1'b1;
      bus.QtTable = 1'(t);
      bus.QtAddr  = 6'(a);
      bus.QtData  = 8'(d);
      @(posedge clk);
      #1;
      bus.QtWe    = 1'b0;
      qt_m[t][a]  = d;
   endtask

   task automatic send_sym(input int run, input int val, input bit eob, input int tsel);
      bit ok;
      int gap;
      gap = int'($urandom_range(0, 2));
      bus.SymValid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.SymRun   = 4'(run);
      bus.SymValue = 12'(val);
      bus.SymEob   = eob;
      bus.SymTable = 1'(tsel);
      bus.SymValid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.SymReady) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("ready_timeout", 32'(bus.SymReady), 32'd1);
      @(posedge clk);
      #1;
      bus.SymValid = 1'b0;
   endtask

   task automatic clear_mon();
      got_addr.delete();
      got_data.delete();
      done_cnt = 0;
      done_we  = 1'b0;
   endtask

   task automatic run_block(input int t);
      clear_mon();
      ref_block(t);
      foreach (syms[i]) begin
         send_sym(syms[i].run, syms[i].val, syms[i].eob,
                  (i == 0) ? t : int'($urandom_range(0, 1)));
      end
      @(negedge clk);
      @(negedge clk);
      err_model = err_model | exp_err;
      check("nwrites", 32'(got_addr.size()), 32'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         check("addr", 32'(got_addr[i]), 32'(exp_addr[i]));
         check("data", 32'(got_data[i]), 32'(exp_data[i]));
      end
      check("block_done", 32'(done_cnt), 32'd1);
      check("done_with_write", 32'(done_we), 32'(exp_end_we));
      check("run_error", 32'(bus.RunError), 32'(err_model));
      check("ready_parked", 32'(bus.SymReady), 32'd0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      check("still_parked", 32'(bus.SymReady), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic release_blk();
      bus.NextBlockEnable = 1'b1;
      @(posedge clk);
      #1;
      bus.NextBlockEnable = 1'b0;
      @(negedge clk);
      check("ready_after_release", 32'(bus.SymReady), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      check("rst_ready", 32'(bus.SymReady), 32'd0);
      check("rst_we",    32'(bus.DataOutEnable), 32'd0);
      check("rst_addr",  32'(bus.DataOutAddress), 32'd0);
      check("rst_data",  32'(bus.DataOut), 32'd0);
      check("rst_done",  32'(bus.BlockDone), 32'd0);
      check("rst_err",   32'(bus.RunError), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.QtWe            = 1'b0;
      bus.QtTable         = 1'b0;
      bus.QtAddr          = 6'd0;
      bus.QtData          = 8'd0;
      bus.SymValid        = 1'b0;
      bus.SymRun          = 4'd0;
      bus.SymValue        = 12'd0;
      bus.SymEob          = 1'b0;
      bus.SymTable        = 1'b0;
      bus.NextBlockEnable = 1'b0;
      err_model           = 1'b0;
      clear_mon();

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int a = 0; a < 64; a++) qt_write(0, a, 1);
      for (int a = 0; a < 64; a++) qt_write(1, a, 2);

      // DC=5, (0,-3), EOB on table 0
      syms.delete();
      add(0, 5, 1'b0); add(0, -3, 1'b0); add(0, 0, 1'b1);
      run_block(0);
      check("t1_n", 32'(got_addr.size()), 32'd2);
      if (got_addr.size() >= 2) begin
         check("t1_d0", 32'(got_data[0]), 32'd5);
         check("t1_a1", 32'(got_addr[1]), 32'd1);
         check("t1_d1", 32'(got_data[1]), 32'h0000FFFD);
      end
      release_blk();

      // DC=7 on table 1, (2,4), EOB
      syms.delete();
      add(0, 7, 1'b0); add(2, 4, 1'b0); add(0, 0, 1'b1);
      run_block(1);
      if (got_addr.size() >= 2) begin
         check("t2_d0", 32'(got_data[0]), 32'd14);
         check("t2_a1", 32'(got_addr[1]), 32'd3);
         check("t2_d1", 32'(got_data[1]), 32'd8);
      end
      release_blk();

      // DC=0, ZRL x3, (14,1): block closes at 63 without EOB
      syms.delete();
      add(0, 0, 1'b0); add(15, 0, 1'b0); add(15, 0, 1'b0); add(15, 0, 1'b0); add(14, 1, 1'b0);
      run_block(0);
      if (got_addr.size() >= 2) begin
         check("t3_a1", 32'(got_addr[1]), 32'd63);
         check("t3_d1", 32'(got_data[1]), 32'd1);
      end
      release_blk();

      // Largest positive product at Q=255
      qt_write(0, 1, 255);
      syms.delete();
      add(0, 3, 1'b0); add(0, 2047, 1'b0); add(0, 0, 1'b1);
      run_block(0);
      if (got_addr.size() >= 2) begin
`ifdef DEQUANT_SATURATE_EN
         check("t5_d1", 32'(got_data[1]), 32'h00007FFF);
`else
         check("t5_d1", 32'(got_data[1]), 32'h0000F701);
`endif
      end
      release_blk();

      for (int t = 0; t < 2; t++)
         for (int a = 0; a < 64; a++)
            qt_write(t, a, ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255)));

      for (int b = 0; b < 40; b++) begin
         gen_block();
         run_block(int'($urandom_range(0, 1)));
         // Table updates while parked
         repeat (4) qt_write(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                             int'($urandom_range(0, 255)));
         release_blk();
      end

      // Overrun: DC=1, ZRL x3, (15,2) targets 64
      syms.delete();
      add(0, 1, 1'b0); add(15, 0, 1'b0); add(15, 0, 1'b0); add(15, 0, 1'b0); add(15, 2, 1'b0);
      run_block(0);
      check("t4_nwrites", 32'(got_addr.size()), 32'd1);
      check("t4_err", 32'(bus.RunError), 32'd1);
      repeat (5) @(negedge clk);
      check("t4_stays_done", 32'(bus.SymReady), 32'd0);
      @(posedge clk);
      #1;
      release_blk();

      // Reset mid-block, then a fresh block must restart at address 0
      clear_mon();
      send_sym(0, 4, 1'b0, 0);
      send_sym(0, 3, 1'b0, 1);
      rst = 1'b0;
      #1;
      check_reset_outputs();
      err_model = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      syms.delete();
      add(0, 9, 1'b0); add(5, -7, 1'b0); add(0, 0, 1'b1);
      run_block(1);
      if (got_addr.size() >= 1) check("t6_a0", 32'(got_addr[0]), 32'd0);
      release_blk();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
